// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcodes, FSM state type and the select-wrap helper used by the ALU sequencer.
package alu_seq_ctrl_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'd0;
   localparam logic [OP_W-1:0] OP_SUB = 3'd1;
   localparam logic [OP_W-1:0] OP_AND = 3'd2;
   localparam logic [OP_W-1:0] OP_XOR = 3'd3;
   localparam logic [OP_W-1:0] OP_MUL = 3'd4;
   localparam logic [OP_W-1:0] OP_DIV = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_DONE
   } state_e;

   // DIV is the last real opcode, so selection wraps back to ADD after it.
   function automatic logic [OP_W-1:0] nextSel(input logic [OP_W-1:0] cur);
      return (cur == OP_DIV) ? OP_ADD : cur + 3'd1;
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q;

   // Counting only while the input disagrees with the accepted level means any
   // bounce back to the old level restarts the run from zero.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         pulse_q <= level_d & ~level_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer between board buttons and the shared multi-cycle ALU: select, launch, await, report.
module alu_seq_ctrl
   import alu_seq_ctrl_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int DEBOUNCE_CYC = 16,
   parameter int TIMEOUT_CYC  = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               btn_next,
   input  logic               btn_go,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic [OP_W-1:0]    sel,
   output logic               alu_start,
   output logic [OP_W-1:0]    alu_op,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   input  logic               alu_done,
   input  logic [2*WIDTH-1:0] alu_result,
   input  logic               alu_err,
   output logic               busy,
   output logic [2*WIDTH-1:0] result,
   output logic               result_valid,
   output logic               err
);

   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic nextPulse, goPulse;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) uNextDb (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn_next),
      .pulse_o (nextPulse)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) uGoDb (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn_go),
      .pulse_o (goPulse)
   );

   state_e             state_q, state_d;
   logic [OP_W-1:0]    sel_q, sel_d;
   logic [OP_W-1:0]    op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               err_q, err_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               divZero;

   assign divZero = (op_q == OP_DIV) && (b_q == '0);

   // A go pulse in IDLE takes precedence, so a simultaneous next pulse is dropped.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      err_d        = err_q;
      tmo_d        = tmo_q;
      alu_start    = 1'b0;
      result_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (goPulse) begin
               a_d     = a_in;
               b_d     = b_in;
               op_d    = sel_q;
               state_d = ST_LAUNCH;
            end else if (nextPulse) begin
               sel_d = nextSel(sel_q);
            end
         end
         ST_LAUNCH: begin
            if (divZero) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = ST_DONE;
            end else begin
               alu_start = 1'b1;
               tmo_d     = '0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (alu_done) begin
               result_d = alu_result;
               err_d    = alu_err;
               state_d  = ST_DONE;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = ST_DONE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_DONE: begin
            result_valid = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         sel_q    <= OP_ADD;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   assign sel    = sel_q;
   assign alu_op = op_q;
   assign alu_a  = a_q;
   assign alu_b  = b_q;
   assign busy   = (state_q != ST_IDLE);
   assign result = result_q;
   assign err    = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomised self-checking bench for alu_seq_ctrl with a behavioural ALU and sequencer model.
module tb_alu_seq_ctrl;

   localparam int W   = 8;
   localparam int DB  = 4;
   localparam int TMO = 24;

   logic          clk = 1'b0;
   logic          reset;
   logic          btn_next, btn_go;
   logic [W-1:0]  a_in, b_in;
   logic [2:0]    sel, alu_op;
   logic          alu_start, alu_done, alu_err;
   logic [W-1:0]  alu_a, alu_b;
   logic [2*W-1:0] alu_result, result;
   logic          busy, result_valid, err;

   int nChecks = 0;
   int nFail   = 0;
   int selModel = 0;

   int aluDelay = 1;
   bit aluHang  = 1'b0;
   bit aluErrInj = 1'b0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.WIDTH(W), .DEBOUNCE_CYC(DB), .TIMEOUT_CYC(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_next     (btn_next),
      .btn_go       (btn_go),
      .a_in         (a_in),
      .b_in         (b_in),
      .sel          (sel),
      .alu_start    (alu_start),
      .alu_op       (alu_op),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_done     (alu_done),
      .alu_result   (alu_result),
      .alu_err      (alu_err),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .err          (err)
   );

   // What the shared ALU computes for each opcode, in plain integer arithmetic.
   function automatic logic [15:0] aluRef(input int op, input int a, input int b);
      case (op)
         0: return 16'(a + b);
         1: return 16'(a - b);
         2: return 16'(a & b);
         3: return 16'(a ^ b);
         4: return 16'(a * b);
         5: return (b == 0) ? 16'hFFFF : 16'(a / b);
         default: return 16'h0;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      if (observed !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Behavioural ALU: answers aluDelay cycles after a start, or never when hung.
   initial begin
      int cnt;
      bit pending;
      int opL, aL, bL;
      bit errL;
      alu_done   = 1'b0;
      alu_result = 16'hDEAD;
      alu_err    = 1'b0;
      pending    = 1'b0;
      cnt = 0; opL = 0; aL = 0; bL = 0; errL = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         alu_done   = 1'b0;
         alu_result = 16'($urandom);
         alu_err    = 1'($urandom);
         if (pending) begin
            if (cnt == 0) begin
               alu_done   = 1'b1;
               alu_result = aluRef(opL, aL, bL);
               alu_err    = errL;
               pending    = 1'b0;
            end else begin
               cnt--;
            end
         end
         if (alu_start && !aluHang) begin
            pending = 1'b1;
            cnt     = aluDelay - 1;
            opL     = int'(alu_op);
            aL      = int'(alu_a);
            bL      = int'(alu_b);
            errL    = aluErrInj;
         end
      end
   end

   task automatic checkResetValues(input string pfx);
      checkOutput({pfx, "_sel"}, sel, 0);
      checkOutput({pfx, "_alu_start"}, alu_start, 0);
      checkOutput({pfx, "_alu_op"}, alu_op, 0);
      checkOutput({pfx, "_alu_a"}, alu_a, 0);
      checkOutput({pfx, "_alu_b"}, alu_b, 0);
      checkOutput({pfx, "_result"}, result, 0);
      checkOutput({pfx, "_err"}, err, 0);
      checkOutput({pfx, "_result_valid"}, result_valid, 0);
      checkOutput({pfx, "_busy"}, busy, 0);
   endtask

   task automatic pressNext();
      btn_next = 1'b1;
      cycles(10);
      btn_next = 1'b0;
      cycles(10);
      selModel = (selModel + 1) % 6;
      checkOutput("sel_after_next", sel, selModel);
   endtask

   // Launches one operation on the currently modelled selection and checks the whole handshake.
   task automatic applyStimulus(input int a, input int b, input int delay, input bit hang,
                                input bit errInj, input bit nextDuring, input bit nextWithGo);
      bit divZ;
      int expLat, lat, cyc, startCnt, busyLow;
      logic [15:0] expRes;
      bit expErr;
      divZ = (selModel == 5) && (b == 0);
      if (divZ) begin
         expLat = 1; expRes = 16'h0; expErr = 1'b1;
      end else if (hang) begin
         expLat = TMO + 1; expRes = 16'h0; expErr = 1'b1;
      end else begin
         expLat = delay + 1; expRes = aluRef(selModel, a, b); expErr = errInj;
      end
      a_in = W'(a);
      b_in = W'(b);
      aluDelay  = delay;
      aluHang   = hang;
      aluErrInj = errInj;
      btn_go = 1'b1;
      if (nextWithGo) btn_next = 1'b1;
      cyc = 0;
      while (!busy && cyc < 30) begin
         cycles(1);
         cyc++;
      end
      checkOutput("go_accepted", busy, 1);
      if (busy) begin
         checkOutput("alu_start_at_launch", alu_start, divZ ? 0 : 1);
         checkOutput("alu_op", alu_op, selModel);
         checkOutput("alu_a", alu_a, a);
         checkOutput("alu_b", alu_b, b);
         startCnt = alu_start ? 1 : 0;
         busyLow = 0;
         lat = 0;
         while (!result_valid && lat < TMO + 20) begin
            cycles(1);
            lat++;
            if (nextDuring) btn_next = (lat >= 1 && lat <= 8);
            if (alu_start) startCnt++;
            if (!busy) busyLow++;
         end
         checkOutput("latency", lat, expLat);
         checkOutput("result", result, expRes);
         checkOutput("err", err, expErr);
         checkOutput("start_pulses", startCnt, divZ ? 0 : 1);
         checkOutput("busy_gaps", busyLow, 0);
         cycles(1);
         checkOutput("valid_one_cycle", result_valid, 0);
         checkOutput("idle_after_done", busy, 0);
         checkOutput("result_held", result, expRes);
      end
      btn_go   = 1'b0;
      btn_next = 1'b0;
      cycles(12);
      checkOutput("sel_unchanged", sel, selModel);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int target, n, a, b;
      reset = 1'b1;
      btn_next = 1'b0;
      btn_go = 1'b0;
      a_in = '0;
      b_in = '0;
      cycles(3);
      checkResetValues("reset");
      reset = 1'b0;
      cycles(2);

      $display("[TB] bounce on next");
      btn_next = 1'b1; cycles(1);
      btn_next = 1'b0; cycles(1);
      btn_next = 1'b1; cycles(10);
      btn_next = 1'b0; cycles(1);
      btn_next = 1'b1; cycles(1);
      btn_next = 1'b0; cycles(10);
      selModel = 1;
      checkOutput("bounce_single_step", sel, 1);

      $display("[TB] wrap through all opcodes");
      repeat (5) pressNext();
      checkOutput("wrap_to_add", sel, 0);

      $display("[TB] MUL 12*11");
      repeat (4) pressNext();
      applyStimulus(12, 11, 3, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mul_value", result, 132);

      $display("[TB] DIV by zero");
      pressNext();
      applyStimulus(77, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] timeout with next pressed during WAIT");
      applyStimulus(9, 3, 1, 1'b1, 1'b0, 1'b1, 1'b0);

      $display("[TB] next and go together");
      applyStimulus(100, 7, 2, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] reset during WAIT");
      pressNext();
      a_in = 8'd5; b_in = 8'd7;
      aluDelay = 12; aluHang = 1'b0; aluErrInj = 1'b0;
      btn_go = 1'b1;
      n = 0;
      while (!busy && n < 30) begin cycles(1); n++; end
      checkOutput("reset_test_launch", busy, 1);
      btn_go = 1'b0;
      cycles(3);
      reset = 1'b1;
      cycles(1);
      checkResetValues("mid_reset");
      selModel = 0;
      reset = 1'b0;
      n = 0;
      repeat (15) begin
         cycles(1);
         if (busy || result_valid) n++;
      end
      checkOutput("late_done_ignored", n, 0);
      checkOutput("result_after_late_done", result, 0);
      applyStimulus(40, 2, 2, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("[TB] randomised operations");
      repeat (16) begin
         target = $urandom_range(0, 5);
         n = (target - selModel + 6) % 6;
         repeat (n) pressNext();
         a = $urandom_range(0, 255);
         b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
         applyStimulus(a, b, $urandom_range(1, 6), ($urandom_range(0, 7) == 0),
                       1'($urandom), 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

endmodule
